mem_arbiter: RTL

//  Round-robin arbiter sharing one single-port mem instance (valid/ready, wr_rd, addr, wdata, rdata) among NREQ requesters.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_arbiter_rr_picker.sv | 30 +++
 rtl/mem_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for mem_arbiter and its round-robin picker.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  // Wraps an index that may have run up to one lap past n-1.
  function automatic int rr_wrap(input int v, input int n);
    return (v >= n) ? v - n : v;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module rr_picker
  import mem_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  logic [IW-1:0] cand;

  always_comb begin
    idx_o = ptr_i;
    any_o = 1'b0;
    cand  = '0;
    // Scan farthest-first so the nearest candidate to the pointer is the last to win.
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IW'(rr_wrap(int'(ptr_i) + k, NREQ));
      if (req_i[cand]) begin
        idx_o = cand;
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port mem among NREQ requesters.
// Optional owner lock (input req_lock) is enabled by defining MEM_ARB_LOCK_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       res,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0]            req_wr_rd,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NREQ*WIDTH-1:0]      req_wdata,
`ifdef MEM_ARB_LOCK_EN
  input  logic [NREQ-1:0]            req_lock,
`endif
  output logic [NREQ-1:0]            done,
  output logic [WIDTH-1:0]           rsp_rdata,
  output logic                       mem_valid,
  output logic                       mem_wr_rd,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  output logic [WIDTH-1:0]           mem_wdata,
  input  logic [WIDTH-1:0]           mem_rdata,
  input  logic                       mem_ready,
  output arb_state_e                 dbg_state
);

  localparam int IW = $clog2(NREQ);

  arb_state_e             state_q, state_d;
  logic [IW-1:0]          ptr_q, ptr_d, idx_q, idx_d;
  logic [NREQ-1:0]        done_q, done_d;
  logic [WIDTH-1:0]       rdata_q, rdata_d, wdata_q, wdata_d;
  logic                   valid_q, valid_d, wr_rd_q, wr_rd_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [IW-1:0]          pick_idx, grant_idx;
  logic                   pick_any, grant_ok;
`ifdef MEM_ARB_LOCK_EN
  logic                   lock_q, lock_d;
`endif

  rr_picker #(.NREQ(NREQ), .IW(IW)) u_picker (
    .req_i (req),
    .ptr_i (ptr_q),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      done_q  <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      wr_rd_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef MEM_ARB_LOCK_EN
      lock_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      wr_rd_q <= wr_rd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef MEM_ARB_LOCK_EN
      lock_q  <= lock_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    done_d    = '0;
    rdata_d   = rdata_q;
    valid_d   = 1'b0;
    wr_rd_d   = wr_rd_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    grant_ok  = 1'b0;
    grant_idx = pick_idx;
`ifdef MEM_ARB_LOCK_EN
    lock_d    = lock_q;
`endif
    unique case (state_q)
      IDLE: begin
        grant_ok = pick_any;
`ifdef MEM_ARB_LOCK_EN
        // A locked owner is the only candidate; it forfeits the lock by dropping req.
        if (lock_q) begin
          if (req[idx_q]) begin
            grant_ok  = 1'b1;
            grant_idx = idx_q;
          end else begin
            lock_d = 1'b0;
          end
        end
`endif
        if (grant_ok) begin
          idx_d   = grant_idx;
          wr_rd_d = req_wr_rd[grant_idx];
          addr_d  = req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d = req_wdata[int'(grant_idx)*WIDTH +: WIDTH];
          valid_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = RESP;
      RESP: begin
        if (mem_ready) begin
          done_d = NREQ'(1) << idx_q;
          if (!wr_rd_q) rdata_d = mem_rdata;
`ifdef MEM_ARB_LOCK_EN
          if (!lock_q) ptr_d = IW'(rr_wrap(int'(idx_q) + 1, NREQ));
`else
          ptr_d = IW'(rr_wrap(int'(idx_q) + 1, NREQ));
`endif
          state_d = DONE;
        end
      end
      DONE: begin
`ifdef MEM_ARB_LOCK_EN
        lock_d = req_lock[idx_q];
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign done      = done_q;
  assign rsp_rdata = rdata_q;
  assign mem_valid = valid_q;
  assign mem_wr_rd = wr_rd_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign dbg_state = state_q;

endmodule
